// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared declarations for the calculator datapath: converter state encoding,
// the width of one BCD digit, and a helper that computes how many decimal
// digits are needed to represent every value of a given binary width.
// No ports (package).
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam int BCD_W = 4;

    // Smallest digit count d such that 10^d > 2^width - 1.
    function automatic int bcd_digits(input int width);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << width) - 64'd1;
        pow10   = 64'd10;
        d       = 1;
        while (pow10 <= max_val) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// -----------------------------------------------------------------------------
// bcd_adjust
// Combinational "add 3" correction step of the double-dabble algorithm.
// Every nibble of the accumulator that is 5 or more gets 3 added, so that the
// following left shift carries correctly into the next decimal digit.
//
// Ports:
//   acc       in   BCD_W*DIGITS  accumulator before the shift
//   adjusted  out  BCD_W*DIGITS  accumulator with per-nibble correction
// -----------------------------------------------------------------------------
module bcd_adjust
    import calc_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [BCD_W*DIGITS-1:0] acc,
    output logic [BCD_W*DIGITS-1:0] adjusted
);

    // Each nibble is corrected independently; the 4-bit add never carries out
    // because a nibble is at most 9 before correction.
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[i*BCD_W +: BCD_W] >= 4'd5) begin
                adjusted[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W] + 4'd3;
            end else begin
                adjusted[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W];
            end
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// -----------------------------------------------------------------------------
// bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Accepts an unsigned WIDTH-bit value over a valid/ready handshake and presents
// packed BCD digits plus a leading-zero blanking mask until consumed.
//
// Ports:
//   clk        in   1             system clock, rising edge
//   rst        in   1             synchronous active-high reset
//   in_valid   in   1             bin holds a value to convert
//   in_ready   out  1             converter can accept a value
//   bin        in   WIDTH         unsigned value to convert
//   out_valid  out  1             bcd/digit_en hold a finished conversion
//   out_ready  in   1             downstream consumes the result
//   bcd        out  4*DIGITS      packed BCD, nibble 0 is least significant
//   digit_en   out  DIGITS        per-digit display enable
//   busy       out  1             conversion in progress
// -----------------------------------------------------------------------------
module bcd_converter
    import calc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]       digit_en,
    output logic                    busy
);

    localparam int ACC_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (DIGITS < bcd_digits(WIDTH)) begin : g_digits_check
            $error("bcd_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    conv_state_t       state;
    conv_state_t       next_state;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  next_sh;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  adj;
    logic [ACC_W-1:0]  next_acc;
    logic              unused_carry;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  bcd_q;
    logic [DIGITS-1:0] en_q;
    logic [DIGITS-1:0] next_en;
    logic              nonzero_seen;

    bcd_adjust #(
        .DIGITS (DIGITS)
    ) u_adjust (
        .acc      (acc),
        .adjusted (adj)
    );

    // The bit shifted out of the top digit is always zero when DIGITS is
    // large enough, so it is simply dropped.
    assign {unused_carry, next_acc, next_sh} = {adj, shreg, 1'b0};

    // Blanking mask: a digit is shown if it or any more significant digit is
    // nonzero; digit 0 is always shown so zero displays as "0".
    always_comb begin
        next_en      = '0;
        nonzero_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nonzero_seen = nonzero_seen | (next_acc[i*BCD_W +: BCD_W] != '0);
            next_en[i]   = nonzero_seen;
        end
        next_en[0] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Leaving DONE always passes through IDLE, so a new
    // value is never accepted in the same cycle as the result handoff.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)              next_state = SHIFT;
            SHIFT:   if (count == CNT_W'(1))    next_state = DONE;
            DONE:    if (out_ready)             next_state = IDLE;
            default:                            next_state = IDLE;
        endcase
    end

    // Datapath: capture, shift-and-add-3, and the output register that only
    // changes on the final shift so partial results are never displayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            count <= '0;
            bcd_q <= '0;
            en_q  <= DIGITS'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= bin;
                        acc   <= '0;
                        count <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    acc   <= next_acc;
                    shreg <= next_sh;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        bcd_q <= next_acc;
                        en_q  <= next_en;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);
    assign bcd       = bcd_q;
    assign digit_en  = en_q;

endmodule

// File: tb/tb_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter
// Scoreboard bench for bcd_converter: the driver pushes expected results
// computed with decimal arithmetic, and an independent monitor pops and
// compares them whenever the converter presents a result.
// -----------------------------------------------------------------------------
module tb_bcd_converter;

    localparam int WIDTH   = 16;
    localparam int DIGITS  = 5;
    localparam int LATENCY = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd;
    logic [4:0]  digit_en;
    logic        busy;

    // 0: always ready, 1: held off, 2: random back-pressure
    int   bp_mode  = 0;
    logic rand_bit = 1'b1;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  en;
        int          accept_cycle;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cycle_cnt = 0;

    bcd_converter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .digit_en  (digit_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) rand_bit = 1'($urandom_range(0, 1));

    assign out_ready = (bp_mode == 2) ? rand_bit : (bp_mode == 0);

    // Reference: decimal digits by repeated division, blanking from the
    // position of the most significant nonzero digit.
    function automatic exp_t model(input int unsigned v, input int acc_cycle);
        exp_t        e;
        int unsigned rem;
        int          top;
        rem = v;
        top = 0;
        e.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[i*4 +: 4] = 4'(rem % 10);
            if (rem % 10 != 0) top = i;
            rem = rem / 10;
        end
        e.en = 5'((32'd1 << (top + 1)) - 32'd1);
        e.accept_cycle = acc_cycle;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got in_ready 0 for 200 cycles, expected 1");
            return;
        end
        in_valid = 1'b1;
        bin      = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin      = 16'($urandom);
        sb.push_back(model(32'(v), cycle_cnt));
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    // Monitor: first cycle of each result is compared against the scoreboard,
    // later cycles of the same result must stay unchanged.
    logic holding  = 1'b0;
    int   busy_run = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            holding  = 1'b0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output: got bcd 0x%0h, expected no result", bcd);
                        cur.bcd = 'x;
                        cur.en  = 'x;
                    end else begin
                        cur = sb.pop_front();
                        checkOutput("bcd", 32'(bcd), 32'(cur.bcd));
                        checkOutput("digit_en", 32'(digit_en), 32'(cur.en));
                        checkOutput("latency", cycle_cnt - cur.accept_cycle, LATENCY);
                        checkOutput("busy_cycles", busy_run, LATENCY);
                    end
                    holding  = 1'b1;
                    busy_run = 0;
                end else begin
                    checkOutput("bcd_hold", 32'(bcd), 32'(cur.bcd));
                    checkOutput("digit_en_hold", 32'(digit_en), 32'(cur.en));
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rand_vals[$];
        int          n;

        rst      = 1'b1;
        in_valid = 1'b0;
        bin      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_bcd", 32'(bcd), 0);
        checkOutput("rst_digit_en", 32'(digit_en), 1);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_rst", 32'(in_ready), 1);

        // Directed values
        applyStimulus(16'd0);
        applyStimulus(16'd40320);
        applyStimulus(16'd65535);
        applyStimulus(16'd120);
        waitIdle();

        // Result held while downstream stalls
        bp_mode = 1;
        applyStimulus(16'd5040);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_out_valid_seen", 32'(out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 1);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
        end
        bp_mode = 0;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 1);
        checkOutput("release_out_valid", 32'(out_valid), 0);

        // Reset in the middle of a conversion
        applyStimulus(16'd720);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_bcd", 32'(bcd), 0);
        checkOutput("abort_digit_en", 32'(digit_en), 1);
        rst = 1'b0;
        applyStimulus(16'd24);
        waitIdle();

        // Reset wins over a simultaneous request
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        bin      = 16'd999;
        #1;
        checkOutput("in_ready_during_rst", 32'(in_ready), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_beats_valid_busy", 32'(busy), 0);

        // in_valid during SHIFT must be ignored
        applyStimulus(16'd6);
        in_valid = 1'b1;
        bin      = 16'd1;
        repeat (8) @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitIdle();
        repeat (20) @(negedge clk);
        checkOutput("ignore_no_extra_busy", 32'(busy), 0);

        // Randomized values with random back-pressure
        rand_vals = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000, 16'd65534};
        repeat (20) rand_vals.push_back(16'($urandom_range(0, 65535)));
        bp_mode = 2;
        foreach (rand_vals[i]) applyStimulus(rand_vals[i]);
        bp_mode = 0;
        waitIdle();

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
